uart_tx_frame_feeder: RTL

- Upstream stage of the UART transmitter: buffers host payload bytes in an internal FIFO.
- On command, emits one framed packet byte-by-byte through the transmitter's load/idle handshake.
- Frame format: SYNC, LEN, payload[0..LEN-1], CSUM.
- Gives the host a fire-and-forget byte interface; no UART timing knowledge needed.

---
 rtl/uart_tx_frame_feeder_if.sv | 23 ++
 rtl/uart_tx_frame_feeder.sv | 90 +++++++++
 2 files changed

// File: rtl/uart_tx_frame_feeder_if.sv
// uart_tx_frame_feeder_if: host byte/command side and transmitter load/idle handshake of the frame feeder
interface uart_tx_frame_feeder_if #(parameter int FIFO_DEPTH = 64);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [7:0] wrDataIN;
  logic wrEnIN;
  logic frameSendIN;
  logic [CW-1:0] fifoCountOUT;
  logic fifoFullOUT;
  logic ovfOUT;
  logic busyOUT;
  logic frameDoneOUT;
  logic [7:0] txDataOUT;
  logic txLoadOUT;
  logic txIdleIN;
  modport master(
    output wrDataIN, wrEnIN, frameSendIN, txIdleIN,
    input fifoCountOUT, fifoFullOUT, ovfOUT, busyOUT, frameDoneOUT, txDataOUT, txLoadOUT
  );
  modport slave(
    input wrDataIN, wrEnIN, frameSendIN, txIdleIN,
    output fifoCountOUT, fifoFullOUT, ovfOUT, busyOUT, frameDoneOUT, txDataOUT, txLoadOUT
  );
endinterface

// File: rtl/uart_tx_frame_feeder.sv
// uart_tx_frame_feeder: buffers host bytes and emits SYNC, LEN, payload, CSUM frames over the UART load/idle handshake
module uart_tx_frame_feeder #(
  parameter int FIFO_DEPTH = 64,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input logic clockIN,
  input logic nTxResetIN,
  uart_tx_frame_feeder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_BUSY = 2'd2, WAIT_IDLE = 2'd3;
  localparam logic [1:0] HDR = 2'd0, LEN = 2'd1, DATA = 2'd2, CSUM = 2'd3;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [1:0] state, field;
  logic [7:0] lenQ, remQ, csum, head, issueByte, txData;
  logic full, push, pop, ovf, busy, done, txLoad;
  assign full = count == CW'(FIFO_DEPTH);
  assign head = mem[rdPtr];
  assign push = bus.wrEnIN && !full;
  assign pop = state == ISSUE && bus.txIdleIN && field == DATA;
  assign issueByte = field == HDR ? SYNC_BYTE : field == LEN ? lenQ : field == DATA ? head : csum;
  assign bus.fifoCountOUT = count;
  assign bus.fifoFullOUT = full;
  assign bus.ovfOUT = ovf;
  assign bus.busyOUT = busy;
  assign bus.frameDoneOUT = done;
  assign bus.txDataOUT = txData;
  assign bus.txLoadOUT = txLoad;
  always_ff @(posedge clockIN)
    if (push) mem[wrPtr] <= bus.wrDataIN;
  always_ff @(posedge clockIN or negedge nTxResetIN)
    if (!nTxResetIN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop) rdPtr <= rdPtr + AW'(1);
      if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
      if (bus.wrEnIN && full) ovf <= 1'b1;
    end
  // remQ counts payload bytes still to issue; lenQ keeps the latched length for the LEN byte
  always_ff @(posedge clockIN or negedge nTxResetIN)
    if (!nTxResetIN) begin
      state <= IDLE;
      field <= HDR;
      lenQ <= '0;
      remQ <= '0;
      csum <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      txData <= '0;
      txLoad <= 1'b0;
    end else begin
      txLoad <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (bus.frameSendIN && count != '0) begin
            state <= ISSUE;
            field <= HDR;
            lenQ <= 8'(count);
            remQ <= 8'(count);
            csum <= '0;
            busy <= 1'b1;
          end
        ISSUE:
          if (bus.txIdleIN) begin
            txData <= issueByte;
            txLoad <= 1'b1;
            state <= WAIT_BUSY;
            if (field == LEN || field == DATA) csum <= csum + (field == LEN ? lenQ : head);
            if (field == DATA) remQ <= remQ - 8'd1;
          end
        WAIT_BUSY:
          if (!bus.txIdleIN) state <= WAIT_IDLE;
        default:
          if (bus.txIdleIN) begin
            state <= field == CSUM ? IDLE : ISSUE;
            field <= field == HDR ? LEN : (field == LEN || (field == DATA && remQ != '0)) ? DATA : CSUM;
            done <= field == CSUM;
            busy <= field != CSUM;
          end
      endcase
    end
endmodule
